// File: rtl/flip_sequencer_if.sv
// Requester/drive bundle for flip_sequencer: digit handshake, rail feedback and status.
// master is the requester/drive side, slave is the sequencer itself.
interface flip_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic [3:0]    req_digit;
  logic          req_ready;
  logic          at_target;
  logic          err_clr;
  logic [3:0]    drv_digit;
  logic          drv_load;
  logic          busy;
  logic          done;
  logic          bad_digit;
  logic          err_timeout;
  logic [CW-1:0] fifo_count;

  modport master (
    output req_valid, req_digit, at_target, err_clr,
    input  req_ready, drv_digit, drv_load, busy, done, bad_digit, err_timeout, fifo_count
  );

  modport slave (
    input  req_valid, req_digit, at_target, err_clr,
    output req_ready, drv_digit, drv_load, busy, done, bad_digit, err_timeout, fifo_count
  );
endinterface

// File: rtl/flip_sequencer.sv
// Command scheduler in front of step_motor_drive: queues requested digits and walks each one
// through move, settle, push (load high) and retract before reporting done.
module flip_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SETTLE_CYC  = 2_000_000,
  parameter int unsigned PUSH_CYC    = 48_000_000,
  parameter int unsigned RETRACT_CYC = 8_000_000,
  parameter int unsigned MOVE_TO     = 400_000_000,
  parameter logic [3:0]  HOME_DIGIT  = 4'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  flip_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MOVE    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_PUSH    = 3'd3;
  localparam logic [2:0] S_RETRACT = 3'd4;

  localparam logic [31:0] MOVE_IGNORE  = 32'd4;
  localparam logic [31:0] MOVE_LAST    = 32'(MOVE_TO - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] PUSH_LAST    = 32'(PUSH_CYC - 1);
  localparam logic [31:0] RETRACT_LAST = 32'(RETRACT_CYC - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [2:0]    r_state;
  logic [31:0]   r_timer;
  logic          r_tgtMeta;
  logic          r_tgtSync;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_drvDigit;
  logic          r_drvLoad;
  logic          r_done;
  logic          r_badDigit;
  logic          r_errTimeout;

  logic          w_ready;
  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic          w_timeout;
  logic          w_finish;
  logic [2:0]    w_nextState;

  assign w_ready  = (r_count < FULL_COUNT);
  assign w_accept = bus.req_valid & w_ready;
  assign w_legal  = (bus.req_digit <= 4'd9);
  assign w_push   = w_accept & w_legal;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !r_errTimeout;

  // The first cycles of MOVE ignore the rail flag: it still reflects the previous digit
  // until the synchronizer and the drive's step recompute have caught up.
  always_comb begin
    w_nextState = r_state;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_pop) w_nextState = S_MOVE;
      S_MOVE: begin
        if (r_tgtSync && (r_timer >= MOVE_IGNORE)) begin
          w_nextState = S_SETTLE;
        end else if (r_timer == MOVE_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!r_tgtSync)                w_nextState = S_MOVE;
        else if (r_timer == SETTLE_LAST) w_nextState = S_PUSH;
      end
      S_PUSH:    if (r_timer == PUSH_LAST) w_nextState = S_RETRACT;
      S_RETRACT: begin
        if (r_timer == RETRACT_LAST) begin
          w_finish    = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_tgtMeta    <= 1'b0;
      r_tgtSync    <= 1'b0;
      r_drvDigit   <= HOME_DIGIT;
      r_drvLoad    <= 1'b0;
      r_done       <= 1'b0;
      r_badDigit   <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      r_tgtMeta  <= bus.at_target;
      r_tgtSync  <= r_tgtMeta;
      r_state    <= w_nextState;
      if (w_nextState != r_state)  r_timer <= '0;
      else if (r_timer != '1)      r_timer <= r_timer + 32'd1;
      r_drvLoad  <= (w_nextState == S_PUSH);
      r_done     <= w_finish;
      r_badDigit <= w_accept & ~w_legal;
      if (w_timeout)  r_drvDigit <= HOME_DIGIT;
      else if (w_pop) r_drvDigit <= r_mem[r_rdPtr];
      if (w_timeout)        r_errTimeout <= 1'b1;
      else if (bus.err_clr) r_errTimeout <= 1'b0;
    end
  end

  // A timeout flush discards everything queued, including a push landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_timeout) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.req_digit;
  end

  assign bus.req_ready   = w_ready;
  assign bus.drv_digit   = r_drvDigit;
  assign bus.drv_load    = r_drvLoad;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.bad_digit   = r_badDigit;
  assign bus.err_timeout = r_errTimeout;
  assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer with short timing parameters and a simple rail model.
module tb_flip_sequencer;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  flip_sequencer_if #(.DEPTH(4)) bus();

  flip_sequencer #(
    .DEPTH(4), .SETTLE_CYC(4), .PUSH_CYC(8), .RETRACT_CYC(3), .MOVE_TO(50), .HOME_DIGIT(4'd0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int         nVec = 0;
  int         nFail = 0;
  logic [3:0] expDigit[$];
  int         expLat[$];
  int         tgtDelay = 10;
  int         glitchAt = 1000;
  int         mdlCnt = 0;
  logic       mdlPrevBusy = 1'b0;
  int         loadCycles = 0;
  int         lat = 0;
  logic       monPrevBusy = 1'b0;
  logic [3:0] popDigit;
  int         popLat;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d);
    bus.req_valid = 1'b1;
    bus.req_digit = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic queueFlip(input logic [3:0] d, input int expectedLat);
    expDigit.push_back(d);
    expLat.push_back(expectedLat);
    applyStimulus(d);
  endtask

  task automatic waitDrain(input int budget);
    logic drained = 1'b0;
    for (int i = 0; i < budget && !drained; i++) begin
      @(negedge clk);
      if (expDigit.size() == 0 && !bus.busy) drained = 1'b1;
    end
    checkOutput("drain_in_time", int'(drained), 1);
  endtask

  // Rail model: the stop flag drops when a command starts and rises tgtDelay cycles later,
  // optionally dropping for two cycles at glitchAt.
  initial begin : railModel
    bus.at_target = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mdlCnt        = 0;
        mdlPrevBusy   = 1'b0;
        bus.at_target = 1'b0;
      end else begin
        if (bus.busy && !mdlPrevBusy) mdlCnt = 0;
        else if (mdlCnt < 100000)     mdlCnt++;
        mdlPrevBusy   = bus.busy;
        bus.at_target = (tgtDelay >= 0) && (mdlCnt >= tgtDelay) &&
                        !((mdlCnt >= glitchAt) && (mdlCnt < glitchAt + 2));
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expected flip.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        loadCycles  = 0;
        lat         = 0;
        monPrevBusy = 1'b0;
      end else begin
        if (bus.drv_load) loadCycles++;
        if (bus.busy && !monPrevBusy) lat = 1;
        else if (bus.busy)            lat++;
        monPrevBusy = bus.busy;
        if (bus.done) begin
          if (expDigit.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            popDigit = expDigit.pop_front();
            popLat   = expLat.pop_front();
            checkOutput("flip_digit", int'(bus.drv_digit), int'(popDigit));
            checkOutput("load_cycles", loadCycles, 8);
            checkOutput("flip_latency", lat, popLat);
          end
          loadCycles = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int   moveCycles;
    logic seen;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_digit = 4'd0;
    bus.err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_drv_digit", int'(bus.drv_digit), 0);
    checkOutput("reset_drv_load", int'(bus.drv_load), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_bad_digit", int'(bus.bad_digit), 0);
    checkOutput("reset_err_timeout", int'(bus.err_timeout), 0);
    checkOutput("reset_fifo_count", int'(bus.fifo_count), 0);
    checkOutput("reset_req_ready", int'(bus.req_ready), 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single flip of digit 6");
    queueFlip(4'd6, 28);
    waitDrain(200);

    $display("[TB] illegal digit 12");
    applyStimulus(4'd12);
    @(negedge clk);
    checkOutput("bad_digit_pulse", int'(bus.bad_digit), 1);
    checkOutput("bad_digit_count", int'(bus.fifo_count), 0);
    checkOutput("bad_digit_busy", int'(bus.busy), 0);
    @(negedge clk);
    checkOutput("bad_digit_one_cycle", int'(bus.bad_digit), 0);

    $display("[TB] rail drops during settle");
    glitchAt = 12;
    queueFlip(4'd5, 35);
    waitDrain(200);
    glitchAt = 1000;

    $display("[TB] move timeout with a queued digit");
    tgtDelay = -1;
    applyStimulus(4'd7);
    applyStimulus(4'd5);
    moveCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.err_timeout) seen = 1'b1;
      else if (bus.busy)   moveCycles++;
    end
    checkOutput("timeout_seen", int'(seen), 1);
    checkOutput("timeout_move_cycles", moveCycles, 50);
    checkOutput("timeout_fifo_flushed", int'(bus.fifo_count), 0);
    checkOutput("timeout_home_digit", int'(bus.drv_digit), 0);
    checkOutput("timeout_busy", int'(bus.busy), 0);

    $display("[TB] fill FIFO while held, then clear error");
    tgtDelay = 10;
    @(posedge clk);
    #1;
    queueFlip(4'd2, 28);
    queueFlip(4'd4, 28);
    queueFlip(4'd8, 28);
    queueFlip(4'd1, 28);
    @(negedge clk);
    checkOutput("full_count", int'(bus.fifo_count), 4);
    checkOutput("full_req_ready", int'(bus.req_ready), 0);
    checkOutput("held_busy", int'(bus.busy), 0);
    checkOutput("held_err", int'(bus.err_timeout), 1);
    applyStimulus(4'd3);
    @(negedge clk);
    checkOutput("full_push_ignored", int'(bus.fifo_count), 4);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", int'(bus.err_timeout), 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready) seen = 1'b1;
    end
    checkOutput("ready_after_pop", int'(seen), 1);
    queueFlip(4'd3, 28);
    waitDrain(600);

    $display("[TB] async reset during push");
    applyStimulus(4'd9);
    applyStimulus(4'd3);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.drv_load) seen = 1'b1;
    end
    checkOutput("reached_push", int'(seen), 1);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_count", int'(bus.fifo_count), 1);
    checkOutput("pre_reset_digit", int'(bus.drv_digit), 9);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_drv_load", int'(bus.drv_load), 0);
    checkOutput("async_busy", int'(bus.busy), 0);
    checkOutput("async_fifo_count", int'(bus.fifo_count), 0);
    checkOutput("async_drv_digit", int'(bus.drv_digit), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] flip after recovery");
    queueFlip(4'd1, 28);
    waitDrain(200);
    checkOutput("scoreboard_empty", expDigit.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
